sprite_rom_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 1-bit sprite ROM read port among N_REQ draw engines
//  (cannon, enemy, laser, bunker/text). Grants one read per cycle, drives the ROM address
//  and sprite select, and routes the returned pixel bit to the winning requester.

---
 rtl/sprite_rom_arbiter_if.sv | 36 +++
 rtl/sprite_rom_arbiter.sv | 112 +++++++++++
 tb/tb_sprite_rom_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_rom_arbiter_if
//  Purpose  : Requester / ROM-bank bus bundle for the sprite ROM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int SEL_W  = 5
);
  logic                    hold;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*SEL_W-1:0]  req_sel;
  logic [N_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]       rom_addr;
  logic [SEL_W-1:0]        rom_sel;
  logic                    rom_data;
  logic [N_REQ-1:0]        rsp_valid;
  logic                    rsp_data;
  logic                    busy;

  // Draw engines plus ROM bank side
  modport master (
    output hold, req, req_addr, req_sel, rom_data,
    input  gnt, rom_addr, rom_sel, rsp_valid, rsp_data, busy
  );

  // Arbiter side
  modport slave (
    input  hold, req, req_addr, req_sel, rom_data,
    output gnt, rom_addr, rom_sel, rsp_valid, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_rom_arbiter
//  Purpose  : Round-robin sharing of one 1-bit sprite ROM read port among
//             N_REQ draw engines, with a fixed two-cycle response pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 19,
  parameter int SEL_W  = 5
) (
  input  wire logic Clk,
  input  wire logic Reset,
  sprite_rom_arbiter_if.slave bus
);

  localparam int c_ptr_w = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int c_idx_w = c_ptr_w + 1;
  localparam logic [c_idx_w-1:0] c_n_req  = c_idx_w'(N_REQ);
  localparam logic [c_ptr_w-1:0] c_last_id = c_ptr_w'(N_REQ - 1);

  logic [c_ptr_w-1:0] r_ptr;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [SEL_W-1:0]   r_rom_sel;
  logic               r_s1_vld;
  logic [c_ptr_w-1:0] r_s1_id;
  logic               r_s2_vld;
  logic [c_ptr_w-1:0] r_s2_id;

  logic [ADDR_W-1:0]  w_addr_arr [N_REQ];
  logic [SEL_W-1:0]   w_sel_arr  [N_REQ];
  logic [c_idx_w-1:0] w_idx;
  logic               w_found;
  logic [c_ptr_w-1:0] w_win_id;
  logic               w_grant_en;
  logic [N_REQ-1:0]   w_gnt;
  logic [c_ptr_w-1:0] w_ptr_next;
  logic [N_REQ-1:0]   w_rsp_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    assign w_sel_arr[gi]  = bus.req_sel[gi*SEL_W +: SEL_W];
  end

  // Rotating priority search starting at r_ptr, wrapping past N_REQ-1
  always_comb begin
    w_idx    = '0;
    w_found  = 1'b0;
    w_win_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + c_idx_w'(k);
      if (w_idx >= c_n_req) begin
        w_idx = w_idx - c_n_req;
      end
      if (!w_found && bus.req[w_idx[c_ptr_w-1:0]]) begin
        w_found  = 1'b1;
        w_win_id = w_idx[c_ptr_w-1:0];
      end
    end
  end

  assign w_grant_en = !Reset && !bus.hold && w_found;

  always_comb begin
    w_gnt = '0;
    if (w_grant_en) begin
      w_gnt[w_win_id] = 1'b1;
    end
  end

  assign w_ptr_next = (w_win_id == c_last_id) ? '0 : w_win_id + 1'b1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr      <= '0;
      r_rom_addr <= '0;
      r_rom_sel  <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_id    <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_id    <= '0;
    end else begin
      r_s1_vld <= w_grant_en;
      if (w_grant_en) begin
        r_ptr      <= w_ptr_next;
        r_rom_addr <= w_addr_arr[w_win_id];
        r_rom_sel  <= w_sel_arr[w_win_id];
        r_s1_id    <= w_win_id;
      end
      // Stage 2 lines up with the ROM's own output register
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
    end
  end

  always_comb begin
    w_rsp_valid = '0;
    if (r_s2_vld) begin
      w_rsp_valid[r_s2_id] = 1'b1;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_sel   = r_rom_sel;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = bus.rom_data & r_s2_vld;
  assign bus.busy      = r_s1_vld | r_s2_vld;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_rom_arbiter
//  Purpose  : Directed bench for sprite_rom_arbiter with a parity ROM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

  localparam int c_n  = 4;
  localparam int c_aw = 19;
  localparam int c_sw = 5;

  logic Clk = 1'b0;
  logic Reset;
  int   nvec  = 0;
  int   nfail = 0;

  sprite_rom_arbiter_if #(.N_REQ(c_n), .ADDR_W(c_aw), .SEL_W(c_sw)) bus ();

  sprite_rom_arbiter #(.N_REQ(c_n), .ADDR_W(c_aw), .SEL_W(c_sw)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic rom_bit(input logic [c_sw-1:0] sel, input logic [c_aw-1:0] addr);
    return (^addr) ^ (^sel);
  endfunction

  // ROM bank model: one registered read per edge
  always_ff @(posedge Clk) bus.rom_data <= rom_bit(bus.rom_sel, bus.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rd(input int i, input logic [c_aw-1:0] a, input logic [c_sw-1:0] s);
    bus.req_addr[i*c_aw +: c_aw] = a;
    bus.req_sel[i*c_sw +: c_sw]  = s;
  endtask

  logic [3:0] gnt_seq [5];
  int         id_seq  [5];

  initial begin
    gnt_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    id_seq  = '{0, 1, 2, 3, 0};
    Reset = 1'b1;
    bus.hold = 1'b0;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_sel = '0;
    tick; tick;

    bus.req = 4'hF;
    #1;
    chk("gnt_in_reset", 32'(bus.gnt), 32'h0);
    tick;
    Reset = 1'b0;
    bus.req = '0;
    #1;
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
    chk("rst_rom_sel", 32'(bus.rom_sel), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);

    // Single read: gnt at T, address at T+1, response at T+2
    set_rd(0, 19'd5, 5'd2);
    bus.req = 4'b0001;
    #1;
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    tick;
    bus.req = '0;
    #1;
    chk("t1_rom_addr", 32'(bus.rom_addr), 32'd5);
    chk("t1_rom_sel", 32'(bus.rom_sel), 32'd2);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 32'h0);
    tick;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data", 32'(bus.rsp_data), 32'(rom_bit(5'd2, 19'd5)));
    tick;
    chk("t1_busy_idle", 32'(bus.busy), 32'h0);

    // Pointer is 1: lone requester 3 wins via wrap, pointer returns to 0
    for (int i = 0; i < c_n; i++) set_rd(i, c_aw'(i), 5'd3);
    bus.req = 4'b1000;
    #1;
    chk("t2_pre_gnt", 32'(bus.gnt), 32'h8);
    tick;

    for (int k = 0; k < 7; k++) begin
      bus.req = (k < 5) ? 4'hF : 4'h0;
      #1;
      chk($sformatf("t2_gnt%0d", k), 32'(bus.gnt), (k < 5) ? 32'(gnt_seq[k]) : 32'h0);
      if (k >= 1 && k < 6)
        chk($sformatf("t2_addr%0d", k), 32'(bus.rom_addr), 32'(id_seq[k-1]));
      if (k >= 2) begin
        chk($sformatf("t2_rspv%0d", k), 32'(bus.rsp_valid), 32'(gnt_seq[k-2]));
        chk($sformatf("t2_rspd%0d", k), 32'(bus.rsp_data),
            32'(rom_bit(5'd3, c_aw'(id_seq[k-2]))));
      end
      tick;
    end

    // Last grant to 2, then 1010 from pointer 3
    bus.req = 4'b0100;
    #1;
    chk("t3_gnt_2", 32'(bus.gnt), 32'h4);
    tick;
    bus.req = 4'b1010;
    #1;
    chk("t3_gnt_3", 32'(bus.gnt), 32'h8);
    tick;
    #1;
    chk("t3_gnt_1", 32'(bus.gnt), 32'h2);
    tick;
    bus.req = '0;

    // Read granted just before hold still drains
    set_rd(0, 19'd6, 5'd1);
    bus.req = 4'b0001;
    #1;
    chk("t4_gnt_pre", 32'(bus.gnt), 32'h1);
    tick;
    bus.hold = 1'b1;
    bus.req = 4'b0100;
    #1;
    chk("t4_hold_gnt0", 32'(bus.gnt), 32'h0);
    chk("t4_rom_addr", 32'(bus.rom_addr), 32'd6);
    chk("t4_rom_sel", 32'(bus.rom_sel), 32'd1);
    tick;
    chk("t4_hold_gnt1", 32'(bus.gnt), 32'h0);
    chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t4_rsp_data", 32'(bus.rsp_data), 32'(rom_bit(5'd1, 19'd6)));
    tick;
    chk("t4_hold_gnt2", 32'(bus.gnt), 32'h0);
    chk("t4_rsp_done", 32'(bus.rsp_valid), 32'h0);
    chk("t4_busy", 32'(bus.busy), 32'h0);
    tick;
    bus.hold = 1'b0;
    #1;
    chk("t4_release_gnt", 32'(bus.gnt), 32'h4);
    tick;
    bus.req = '0;

    // Two reads in flight, then a one-cycle reset
    set_rd(3, 19'h1234, 5'd7);
    bus.req = 4'b1000;
    #1;
    chk("t5_gnt_a", 32'(bus.gnt), 32'h8);
    tick;
    bus.req = 4'b0001;
    #1;
    chk("t5_gnt_b", 32'(bus.gnt), 32'h1);
    tick;
    Reset = 1'b1;
    bus.req = '0;
    #1;
    chk("t5_busy_pre", 32'(bus.busy), 32'h1);
    chk("t5_rspv_pre", 32'(bus.rsp_valid), 32'h8);
    tick;
    Reset = 1'b0;
    set_rd(3, 19'd9, 5'd4);
    bus.req = 4'b1000;
    #1;
    chk("t5_rspv_drop", 32'(bus.rsp_valid), 32'h0);
    chk("t5_busy_drop", 32'(bus.busy), 32'h0);
    chk("t5_rom_addr0", 32'(bus.rom_addr), 32'h0);
    chk("t5_rom_sel0", 32'(bus.rom_sel), 32'h0);
    chk("t5_gnt_3", 32'(bus.gnt), 32'h8);
    tick;

    // Idle after a read to addr 9
    bus.req = '0;
    #1;
    chk("t6_rom_addr", 32'(bus.rom_addr), 32'd9);
    chk("t6_rom_sel", 32'(bus.rom_sel), 32'd4);
    chk("t6_busy", 32'(bus.busy), 32'h1);
    chk("t6_rsp_gone", 32'(bus.rsp_valid), 32'h0);
    tick;
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h8);
    chk("t6_rsp_data", 32'(bus.rsp_data), 32'(rom_bit(5'd4, 19'd9)));
    tick;
    chk("t6_rsp_idle", 32'(bus.rsp_valid), 32'h0);
    chk("t6_data_gated", 32'(bus.rsp_data), 32'h0);
    chk("t6_busy_idle", 32'(bus.busy), 32'h0);
    chk("t6_addr_hold", 32'(bus.rom_addr), 32'd9);
    chk("t6_gnt_idle", 32'(bus.gnt), 32'h0);
    tick;
    chk("t6_addr_hold2", 32'(bus.rom_addr), 32'd9);
    chk("t6_data_gated2", 32'(bus.rsp_data), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
